// File: rtl/datamem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
// Imported by the memory top and the load aligner.
package datamem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        DM_INIT = 1'b0,
        DM_RUN  = 1'b1
    } dm_state_e;

    function automatic logic [3:0] lane_mask(
        input mem_size_e  sz,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = 4'b0011 << off;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/datamem_load_align.sv
// Selects the addressed byte/half of a word and extends it to 32 bits.
// Purely combinational so it can sit behind any registered read port.
module datamem_load_align
    import datamem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  mem_size_e   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sb;
    logic        w_sh;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    assign w_sb   = ~i_unsigned & w_byte[7];
    assign w_sh   = ~i_unsigned & w_half[15];

    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_BYTE: o_data = {{24{w_sb}}, w_byte};
            SZ_HALF: o_data = {{16{w_sh}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/datamem_bytelane.sv
// Byte-addressable MEM-stage data memory with lane writes, registered
// read response, fault reporting and hardware zeroing after reset.
module datamem_bytelane
    import datamem_pkg::*;
#(
    parameter  int MEM_WORDS = 32,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        init_done
);

    logic [31:0]      r_mem [MEM_WORDS];
    dm_state_e        r_state;
    logic [IDX_W-1:0] r_icnt;
    logic             r_ready;
    logic             r_init_done;
    logic             r_rsp_valid;
    logic [31:0]      r_rdata;
    logic             r_fault;

    mem_size_e        w_size;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_widx;
    logic             w_acc;
    logic             w_fault;
    logic             w_st;
    logic [3:0]       w_be;
    logic [31:0]      w_wrep;
    logic [31:0]      w_word;
    logic [31:0]      w_ld;

    assign w_size = mem_size_e'(req_size);
    assign w_off  = req_addr[1:0];
    assign w_widx = req_addr[IDX_W+1:2];
    assign w_acc  = req_valid & r_ready;

    assign w_fault = (w_size == SZ_RSVD)
                   | ((w_size == SZ_HALF) & w_off[0])
                   | ((w_size == SZ_WORD) & (|w_off))
                   | (|req_addr[31:IDX_W+2]);

    assign w_st = w_acc & req_write & ~w_fault;
    assign w_be = lane_mask(w_size, w_off);

    always_comb begin
        w_wrep = req_wdata;
        case (w_size)
            SZ_BYTE: w_wrep = {4{req_wdata[7:0]}};
            SZ_HALF: w_wrep = {2{req_wdata[15:0]}};
            default: w_wrep = req_wdata;
        endcase
    end

    assign w_word = r_mem[w_widx];

    datamem_load_align u_align (
        .i_word     (w_word),
        .i_off      (w_off),
        .i_size     (w_size),
        .i_unsigned (req_unsigned),
        .o_data     (w_ld)
    );

    // Array is never reset; INIT zeroing is its only defined start state.
    always_ff @(posedge clk) begin
        if (r_state == DM_INIT) begin
            r_mem[r_icnt] <= '0;
        end else if (w_st) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_widx][8*i +: 8] <= w_wrep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DM_INIT;
            r_icnt      <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_rsp_valid <= w_acc;
            if (w_acc) begin
                r_rdata <= (w_fault | req_write) ? '0 : w_ld;
                r_fault <= w_fault;
            end
            case (r_state)
                DM_INIT: begin
                    r_icnt <= r_icnt + 1'b1;
                    if (&r_icnt) begin
                        r_state     <= DM_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                DM_RUN: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
                default: r_state <= DM_INIT;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;

endmodule

// File: tb/tb_datamem_bytelane.sv
// Directed self-checking bench for datamem_bytelane (MEM_WORDS = 32).
// Expected values are hand-computed constants.
module tb_datamem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_done;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    always #5 clk = ~clk;

    datamem_bytelane #(.MEM_WORDS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .init_done    (init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clk);
        #1;
    endtask

    // One isolated request, then check its response cycle.
    task automatic xfer(input string tag, input logic w,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_f);
        drive(w, sz, u, a, d);
        req_valid = 1'b0;
        check({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".data"}, rsp_rdata, exp_d);
        check({tag, ".fault"}, {31'b0, rsp_fault}, {31'b0, exp_f});
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".init_cycles"}, n, 32'd32);
        check({tag, ".init_done"}, {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", {31'b0, req_ready}, 32'd0);
        check("rst.init_done", {31'b0, init_done}, 32'd0);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.fault", {31'b0, rsp_fault}, 32'd0);
        rst_n = 1'b1;
        wait_ready("boot");
        xfer("lw7c", 1'b0, 2'b10, 1'b0, 32'h7C, 0, 32'h0, 1'b0);

        // lane stores
        xfer("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0);
        xfer("sb1", 1'b1, 2'b00, 1'b0, 32'h1, 32'h000000AB, 32'h0, 1'b0);
        xfer("sh2", 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF, 32'h0, 1'b0);
        xfer("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 0, 32'hBEEFAB44, 1'b0);

        // extension
        xfer("sw4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h80FF7F01, 32'h0, 1'b0);
        xfer("lb7", 1'b0, 2'b00, 1'b0, 32'h7, 0, 32'hFFFFFF80, 1'b0);
        xfer("lbu7", 1'b0, 2'b00, 1'b1, 32'h7, 0, 32'h00000080, 1'b0);
        xfer("lh4", 1'b0, 2'b01, 1'b0, 32'h4, 0, 32'h00007F01, 1'b0);
        xfer("lhu6", 1'b0, 2'b01, 1'b1, 32'h6, 0, 32'h000080FF, 1'b0);
        xfer("lh6", 1'b0, 2'b01, 1'b0, 32'h6, 0, 32'hFFFF80FF, 1'b0);
        xfer("lbu5", 1'b0, 2'b00, 1'b1, 32'h5, 0, 32'h0000007F, 1'b0);

        // faults
        xfer("lh3", 1'b0, 2'b01, 1'b0, 32'h3, 0, 32'h0, 1'b1);
        xfer("lw2", 1'b0, 2'b10, 1'b0, 32'h2, 0, 32'h0, 1'b1);
        xfer("rsvd", 1'b1, 2'b11, 1'b0, 32'h0, 32'h55555555, 32'h0, 1'b1);
        xfer("sw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0, 1'b1);
        xfer("sh5", 1'b1, 2'b01, 1'b0, 32'h5, 32'h0000FFFF, 32'h0, 1'b1);
        xfer("lw0.after", 1'b0, 2'b10, 1'b0, 32'h0, 0, 32'hBEEFAB44, 1'b0);
        xfer("lw4.after", 1'b0, 2'b10, 1'b0, 32'h4, 0, 32'h80FF7F01, 1'b0);

        // back-to-back store then load
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
        check("b2b.st.valid", {31'b0, rsp_valid}, 32'd1);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 0);
        req_valid = 1'b0;
        check("b2b.ld.valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b.ld.data", rsp_rdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("b2b.idle.valid", {31'b0, rsp_valid}, 32'd0);
        check("b2b.hold.data", rsp_rdata, 32'hCAFEF00D);

        // reset in the response cycle of a store
        drive(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
        req_valid = 1'b0;
        check("mid.st.valid", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid.ready", {31'b0, req_ready}, 32'd0);
        check("mid.init_done", {31'b0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // requests during INIT must be ignored
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h8;
        req_wdata = 32'hA5A5A5A5;
        repeat (4) @(posedge clk);
        #1;
        check("init.ignored", {31'b0, rsp_valid}, 32'd0);
        req_valid = 1'b0;
        n = 4;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reinit.cycles", n, 32'd32);
        xfer("lw8.reinit", 1'b0, 2'b10, 1'b0, 32'h8, 0, 32'h0, 1'b0);
        xfer("lw0.reinit", 1'b0, 2'b10, 1'b0, 32'h0, 0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
